// File: rtl/morph_pkg.sv
// Shared definitions for the binary morphology filter: mode encodings,
// output colour defaults and the border padding values.
package morph_pkg;

  // Run-time operation select, sampled together with each pixel
  typedef enum logic [1:0] {
    MODE_ERODE  = 2'b00,
    MODE_DILATE = 2'b01,
    MODE_BYPASS = 2'b10,
    MODE_GRAD   = 2'b11
  } mode_e;

  // rgb_out drive levels for a 1 / 0 result
  localparam logic [11:0] COLOR_ON_DEFAULT = 12'hFFF;
  localparam logic [11:0] COLOR_OFF        = 12'h000;

  // Out-of-image taps read as the identity of each operator, so the frame
  // border is neither eaten away by erode nor grown by dilate.
  localparam logic PAD_ERODE  = 1'b1;
  localparam logic PAD_DILATE = 1'b0;

endpackage

// File: rtl/morph_linebuf.sv
// One line of 1-bit delay: single-port RAM addressed by column, read
// combinationally before the write at the same address lands. Cascading
// several of these yields the pixels 1, 2, ... lines above the input.
// Contents are deliberately not reset; stale data is masked downstream.
module morph_linebuf
  import morph_pkg::*;
#(
  parameter int IMG_W = 1024,
  parameter int AW    = 11
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic          din,
  output logic          dout
);

  localparam int IW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int DEPTH = 1 << IW;

  logic            ram [0:DEPTH-1];
  logic [IW-1:0]   idx_s;
  logic            in_range_s;

  // Address decode and read of the previous line's pixel at this column
  always_comb begin
    in_range_s = (addr < AW'(IMG_W));
    idx_s      = addr[IW-1:0];
    if (in_range_s) begin
      dout = ram[idx_s];
    end else begin
      dout = 1'b0;
    end
  end

  // Store the current pixel for use one line later
  always_ff @(posedge clk) begin
    if (we && in_range_s) begin
      ram[idx_s] <= din;
    end
  end

endmodule

// File: rtl/morph_filter.sv
// KSIZE x KSIZE binary erode / dilate / bypass / gradient over a raster
// stream. Stage 1 shifts the pixel into the window and registers its
// coordinates; stage 2 masks padding taps and registers the result, so a
// pixel's result is visible two clocks after it is presented.
module morph_filter
  import morph_pkg::*;
#(
  parameter int          IMG_W    = 1024,
  parameter int          IMG_H    = 768,
  parameter int          KSIZE    = 3,
  parameter int          HC_W     = 11,
  parameter logic [11:0] COLOR_ON = COLOR_ON_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [HC_W-1:0] hcount,
  input  logic [HC_W-1:0] vcount,
  input  logic            sobel_value,
  input  logic [1:0]      mode,
  output logic            out_valid,
  output logic [HC_W-1:0] out_hcount,
  output logic [HC_W-1:0] out_vcount,
  output logic            morph_value,
  output logic [11:0]     rgb_out
);

  localparam int R   = (KSIZE - 1) / 2;
  localparam int NLB = KSIZE - 1;
  localparam int LSW = $clog2(KSIZE);

  localparam logic [LSW-1:0]  LS_MAX = LSW'(KSIZE - 1);
  localparam logic [HC_W-1:0] W_C    = HC_W'(IMG_W);
  localparam logic [HC_W-1:0] H_C    = HC_W'(IMG_H);
  localparam logic [HC_W-1:0] LAST_C = HC_W'(IMG_W - 1);
  localparam logic [HC_W-1:0] R_C    = HC_W'(R);

  logic                         in_act_s;
  logic                         frame_start_s;
  logic                         line_end_s;
  logic [NLB-1:0]               lb_in_s;
  logic [NLB-1:0]               lb_out_s;
  logic [KSIZE-1:0]             col_s;

  // Window rows j = lines above the newest row, bits k = columns left of newest
  logic [KSIZE-1:0][KSIZE-1:0]  win_d, win_q;
  logic [LSW-1:0]               lines_seen_d, lines_seen_q;

  // Stage-1 side information travelling with the window
  logic                         act_d, act_q;
  logic [HC_W-1:0]              h_d, h_q;
  logic [HC_W-1:0]              v_d, v_q;
  mode_e                        mode_d, mode_q;
  logic [LSW-1:0]               ls_d, ls_q;

  logic                         ero_s, dil_s, ctr_s, res_s;

  logic                         out_valid_d, out_valid_q;
  logic [HC_W-1:0]              out_hcount_d, out_hcount_q;
  logic [HC_W-1:0]              out_vcount_d, out_vcount_q;
  logic                         morph_d, morph_q;
  logic [11:0]                  rgb_d, rgb_q;

  assign in_act_s      = (hcount < W_C) && (vcount < H_C);
  assign frame_start_s = (hcount == '0) && (vcount == '0);
  assign line_end_s    = (hcount == LAST_C);

  // Newest window column: current pixel at the bottom, line buffers above
  assign col_s = {lb_out_s, sobel_value};

  for (genvar g = 0; g < NLB; g++) begin : g_lb
    if (g == 0) begin : g_first
      assign lb_in_s[g] = sobel_value;
    end else begin : g_next
      assign lb_in_s[g] = lb_out_s[g-1];
    end
    morph_linebuf #(
      .IMG_W (IMG_W),
      .AW    (HC_W)
    ) u_linebuf (
      .clk  (clk),
      .we   (in_act_s),
      .addr (hcount),
      .din  (lb_in_s[g]),
      .dout (lb_out_s[g])
    );
  end

  // Window shift on active pixels only; blanking holds it still
  always_comb begin
    win_d = win_q;
    if (in_act_s) begin
      for (int j = 0; j < KSIZE; j++) begin
        win_d[j] = {win_q[j][KSIZE-2:0], col_s[j]};
      end
    end else begin
      win_d = win_q;
    end
  end

  // Count completed lines of this frame (saturating) to mask unfilled rows
  always_comb begin
    if (in_act_s && frame_start_s) begin
      lines_seen_d = '0;
    end else if (in_act_s && line_end_s && (lines_seen_q != LS_MAX)) begin
      lines_seen_d = lines_seen_q + LSW'(1);
    end else begin
      lines_seen_d = lines_seen_q;
    end
  end

  // Capture per-pixel context that the result stage needs one clock later
  always_comb begin
    act_d  = in_act_s;
    h_d    = hcount;
    v_d    = vcount;
    mode_d = mode_e'(mode);
    if (frame_start_s) begin
      ls_d = '0;
    end else begin
      ls_d = lines_seen_q;
    end
  end

  // Reduce the padded window: unfilled rows and off-left columns use pad values
  always_comb begin
    ero_s = 1'b1;
    dil_s = 1'b0;
    for (int j = 0; j < KSIZE; j++) begin
      for (int k = 0; k < KSIZE; k++) begin
        if ((ls_q >= LSW'(j)) && (h_q >= HC_W'(k))) begin
          ero_s = ero_s & win_q[j][k];
          dil_s = dil_s | win_q[j][k];
        end else begin
          ero_s = ero_s & PAD_ERODE;
          dil_s = dil_s | PAD_DILATE;
        end
      end
    end
    ctr_s = win_q[R][R];
  end

  // Select the operation and form the next output register values
  always_comb begin
    case (mode_q)
      MODE_ERODE:  res_s = ero_s;
      MODE_DILATE: res_s = dil_s;
      MODE_BYPASS: res_s = ctr_s;
      MODE_GRAD:   res_s = dil_s ^ ero_s;
      default:     res_s = ero_s;
    endcase
    out_valid_d  = act_q && (h_q >= R_C) && (v_q >= R_C);
    out_hcount_d = h_q - R_C;
    out_vcount_d = v_q - R_C;
    if (out_valid_d) begin
      morph_d = res_s;
    end else begin
      morph_d = 1'b0;
    end
    if (morph_d) begin
      rgb_d = COLOR_ON;
    end else begin
      rgb_d = COLOR_OFF;
    end
  end

  // Window, line counter and stage-1 context registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q        <= '0;
      lines_seen_q <= '0;
      act_q        <= 1'b0;
      h_q          <= '0;
      v_q          <= '0;
      mode_q       <= MODE_ERODE;
      ls_q         <= '0;
    end else begin
      win_q        <= win_d;
      lines_seen_q <= lines_seen_d;
      act_q        <= act_d;
      h_q          <= h_d;
      v_q          <= v_d;
      mode_q       <= mode_d;
      ls_q         <= ls_d;
    end
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_hcount_q <= '0;
      out_vcount_q <= '0;
      morph_q      <= 1'b0;
      rgb_q        <= 12'h000;
    end else begin
      out_valid_q  <= out_valid_d;
      out_hcount_q <= out_hcount_d;
      out_vcount_q <= out_vcount_d;
      morph_q      <= morph_d;
      rgb_q        <= rgb_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_hcount  = out_hcount_q;
  assign out_vcount  = out_vcount_q;
  assign morph_value = morph_q;
  assign rgb_out     = rgb_q;

endmodule

// File: tb/tb_morph_filter.sv
// Directed bench for morph_filter: a KSIZE=3 and a KSIZE=5 instance share
// one raster stream on a reduced 40x36 image. Expected outputs come from an
// image-level reference (padded neighbourhood of the known pattern) plus
// hand-computed coordinates and per-frame pixel counts.
module tb_morph_filter;

  localparam int W    = 40;
  localparam int H    = 36;
  localparam int HB   = 3;
  localparam int HC_W = 11;

  logic            clk = 1'b0;
  logic            rst;
  logic [HC_W-1:0] hcount, vcount;
  logic            sobel_value;
  logic [1:0]      mode;

  logic            o3_valid, o5_valid, o3_morph, o5_morph;
  logic [HC_W-1:0] o3_h, o3_v, o5_h, o5_v;
  logic [11:0]     o3_rgb, o5_rgb;

  int checks   = 0;
  int failures = 0;
  int pat_id, px, py, row0;
  int valid3, valid5, ones3, ones5;

  typedef struct {
    bit act;
    int h;
    int v;
    int m;
    bit cv;
  } hist_t;

  hist_t hq1, hq2;

  always #5 clk = ~clk;

  morph_filter #(.IMG_W(W), .IMG_H(H), .KSIZE(3), .HC_W(HC_W), .COLOR_ON(12'hFFF)) u_dut3 (
    .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount), .sobel_value(sobel_value),
    .mode(mode), .out_valid(o3_valid), .out_hcount(o3_h), .out_vcount(o3_v),
    .morph_value(o3_morph), .rgb_out(o3_rgb));

  morph_filter #(.IMG_W(W), .IMG_H(H), .KSIZE(5), .HC_W(HC_W), .COLOR_ON(12'hFFF)) u_dut5 (
    .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount), .sobel_value(sobel_value),
    .mode(mode), .out_valid(o5_valid), .out_hcount(o5_h), .out_vcount(o5_v),
    .morph_value(o5_morph), .rgb_out(o5_rgb));

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", tag, $time, act, exp);
    end
  endtask

  function automatic bit pix(input int x, input int y);
    case (pat_id)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return (x == px) && (y == py);
      default: return (x % 2) == 1;
    endcase
  endfunction

  // Reference: padded neighbourhood of the known image around (cx,cy)
  function automatic bit model(input int k, input int m, input int cx, input int cy);
    int r;
    bit e, d, c;
    r = (k - 1) / 2;
    e = 1'b1;
    d = 1'b0;
    for (int dy = -r; dy <= r; dy++) begin
      for (int dx = -r; dx <= r; dx++) begin
        if ((cx + dx >= 0) && (cy + dy >= row0)) begin
          e = e & pix(cx + dx, cy + dy);
          d = d | pix(cx + dx, cy + dy);
        end
      end
    end
    c = pix(cx, cy);
    case (m)
      0:       return e;
      1:       return d;
      2:       return c;
      default: return d ^ e;
    endcase
  endfunction

  function automatic int mode_of(input int sel, input int h);
    if (sel < 4) return sel;
    else return (h / 3) % 4;
  endfunction

  task automatic check_inst(input string nm, input int k, input hist_t e, input logic av,
                            input logic [HC_W-1:0] ah, input logic [HC_W-1:0] avc,
                            input logic am, input logic [11:0] argb);
    int r;
    bit ev, ex;
    r  = (k - 1) / 2;
    ev = e.act && (e.h >= r) && (e.v >= r);
    check_eq({nm, ".valid"}, 32'(av), 32'(ev));
    if (ev) begin
      check_eq({nm, ".hcount"}, 32'(ah), 32'(e.h - r));
      check_eq({nm, ".vcount"}, 32'(avc), 32'(e.v - r));
      if (e.cv) begin
        ex = model(k, e.m, e.h - r, e.v - r);
        check_eq({nm, ".value"}, 32'(am), 32'(ex));
        check_eq({nm, ".rgb"}, 32'(argb), ex ? 32'hFFF : 32'h0);
      end
    end else begin
      check_eq({nm, ".value_idle"}, 32'(am), 32'h0);
      check_eq({nm, ".rgb_idle"}, 32'(argb), 32'h0);
    end
  endtask

  task automatic clear_hist();
    hq1 = '{act: 1'b0, h: 0, v: 0, m: 0, cv: 1'b0};
    hq2 = hq1;
  endtask

  task automatic clear_counts();
    valid3 = 0; valid5 = 0; ones3 = 0; ones5 = 0;
  endtask

  // One clock: check the result of the pixel presented two clocks ago, then drive
  task automatic step(input int h, input int v, input int m, input bit cv);
    hist_t cur;
    @(posedge clk);
    #1;
    check_inst("k3", 3, hq2, o3_valid, o3_h, o3_v, o3_morph, o3_rgb);
    check_inst("k5", 5, hq2, o5_valid, o5_h, o5_v, o5_morph, o5_rgb);
    if (o3_valid === 1'b1) begin
      valid3++;
      if (o3_morph === 1'b1) ones3++;
    end
    if (o5_valid === 1'b1) begin
      valid5++;
      if (o5_morph === 1'b1) ones5++;
    end
    hq2     = hq1;
    cur.act = (rst == 1'b0) && (h < W) && (v < H);
    cur.h   = h;
    cur.v   = v;
    cur.m   = m;
    cur.cv  = cv;
    hq1     = cur;
    hcount      = HC_W'(h);
    vcount      = HC_W'(v);
    mode        = 2'(m);
    sobel_value = pix(h, v);
  endtask

  // Full lines v0..v1 including horizontal blanking; v == H is a blank line
  task automatic run_lines(input int v0, input int v1, input int sel);
    for (int v = v0; v <= v1; v++) begin
      for (int h = 0; h < W + HB; h++) begin
        step(h, v, mode_of(sel, h), 1'b1);
      end
    end
  endtask

  task automatic run_frame(input int sel, input string nm, input int e3, input int e5);
    clear_counts();
    run_lines(0, H, sel);
    check_eq({nm, ".ones3"}, 32'(ones3), 32'(e3));
    check_eq({nm, ".ones5"}, 32'(ones5), 32'(e5));
  endtask

  initial begin
    rst = 1'b1; hcount = '0; vcount = '0; sobel_value = 1'b0; mode = 2'b00;
    pat_id = 0; px = 0; py = 0; row0 = 0;
    clear_hist();
    clear_counts();
    #12;
    check_eq("rst.valid3", 32'(o3_valid), 32'h0);
    check_eq("rst.morph3", 32'(o3_morph), 32'h0);
    check_eq("rst.rgb3", 32'(o3_rgb), 32'h0);
    check_eq("rst.hcount3", 32'(o3_h), 32'h0);
    check_eq("rst.valid5", 32'(o5_valid), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Latency and coordinate offsets
    step(20, 5, 0, 1'b0);
    step(21, 5, 0, 1'b0);
    step(W, 5, 0, 1'b0);
    check_eq("lat.a.valid3", 32'(o3_valid), 32'h1);
    check_eq("lat.a.h3", 32'(o3_h), 32'd19);
    check_eq("lat.a.v3", 32'(o3_v), 32'd4);
    check_eq("lat.a.h5", 32'(o5_h), 32'd18);
    check_eq("lat.a.v5", 32'(o5_v), 32'd3);
    step(W + 1, 5, 0, 1'b0);
    check_eq("lat.b.valid3", 32'(o3_valid), 32'h1);
    check_eq("lat.b.h3", 32'(o3_h), 32'd20);
    check_eq("lat.b.v3", 32'(o3_v), 32'd4);
    step(W + 2, 5, 0, 1'b0);
    check_eq("lat.blank.valid3", 32'(o3_valid), 32'h0);
    step(1, 2, 0, 1'b0);
    step(2, 2, 0, 1'b0);
    step(W, 2, 0, 1'b0);
    check_eq("edge.k5_h1.valid", 32'(o5_valid), 32'h0);
    check_eq("edge.k3_h1.h", 32'(o3_h), 32'd0);
    check_eq("edge.k3_h1.v", 32'(o3_v), 32'd1);
    step(W + 1, 2, 0, 1'b0);
    check_eq("first5.valid", 32'(o5_valid), 32'h1);
    check_eq("first5.h", 32'(o5_h), 32'd0);
    check_eq("first5.v", 32'(o5_v), 32'd0);

    // All-ones frame, erode: every emitted pixel is 1, borders included
    pat_id = 1;
    run_frame(0, "ones.erode", (W - 1) * (H - 1), (W - 2) * (H - 2));
    check_eq("ones.valid3", 32'(valid3), 32'((W - 1) * (H - 1)));
    check_eq("ones.valid5", 32'(valid5), 32'((W - 2) * (H - 2)));

    // Single pixel at (10,10)
    pat_id = 2; px = 10; py = 10;
    run_frame(1, "dot.dilate", 9, 25);
    run_frame(0, "dot.erode", 0, 0);
    run_frame(3, "dot.grad", 9, 25);
    run_frame(2, "dot.bypass", 1, 1);

    // Alternating columns
    pat_id = 3;
    run_frame(0, "alt.erode", 0, 0);
    run_frame(1, "alt.dilate", (W - 1) * (H - 1), (W - 2) * (H - 2));
    run_frame(3, "alt.grad", (W - 1) * (H - 1), (W - 2) * (H - 2));

    // Mode changing every three pixels mid-line
    pat_id = 2; px = 10; py = 10;
    clear_counts();
    run_lines(0, H, 4);

    // Stale line buffers: zeros up to mid row 5, reset, then ones from row 5
    pat_id = 0;
    run_lines(0, 4, 0);
    for (int h = 0; h < 20; h++) step(h, 5, 0, 1'b1);
    rst = 1'b1;
    #1;
    check_eq("rst_mid.valid3", 32'(o3_valid), 32'h0);
    check_eq("rst_mid.valid5", 32'(o5_valid), 32'h0);
    check_eq("rst_mid.rgb3", 32'(o3_rgb), 32'h0);
    clear_hist();
    pat_id = 1;
    for (int h = 20; h < 23; h++) step(h, 5, 0, 1'b1);
    step(W, 5, 0, 1'b1);
    rst  = 1'b0;
    row0 = 5;
    clear_counts();
    run_lines(5, H, 0);
    check_eq("stale.valid3", 32'(valid3), 32'((W - 1) * (H - 5)));
    check_eq("stale.ones3", 32'(ones3), 32'((W - 1) * (H - 5)));
    check_eq("stale.ones5", 32'(ones5), 32'((W - 2) * (H - 5)));
    row0 = 0;

    // Single pixel at (30,30): 5x5 block at 28..32 for KSIZE 5
    pat_id = 2; px = 30; py = 30;
    run_frame(1, "dot30.dilate", 9, 25);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/morph_filter.md
Name: morph_filter

Overview:
- Parametrised binary morphology filter for the edge-detect pipeline; successor to the fixed 3x3 erode stage.
- Consumes the 1-bit Sobel edge stream in raster order, together with hcount/vcount.
- Applies a KSIZE x KSIZE square erode, dilate, bypass or gradient, selectable at run time.
- Emits a 1-bit result, a 12-bit RGB pixel and delayed coordinates to the VGA output mux.

Parameters:
- IMG_W, 1024, active pixels per line
- IMG_H, 768, active lines per frame
- KSIZE, 3, kernel side; legal values 3 or 5; R=(KSIZE-1)/2
- HC_W, 11, hcount/vcount width
- COLOR_ON, 12'hFFF, rgb_out value when result is 1 (result 0 gives 12'h000)

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- hcount  in  HC_W  current input column
- vcount  in  HC_W  current input row
- sobel_value  in  1  binary edge pixel at (hcount,vcount)
- mode  in  2  00 erode, 01 dilate, 10 bypass, 11 gradient
- out_valid  out  1  result below is an active pixel
- out_hcount  out  HC_W  column of result
- out_vcount  out  HC_W  row of result
- morph_value  out  1  binary result
- rgb_out  out  12  COLOR_ON or 12'h000

Behaviour:
- Active input: in_act = hcount<IMG_W && vcount<IMG_H. Blanking cycles do not shift the window, do not write line buffers and force out_valid=0 two cycles later.
- Line buffers: KSIZE-1 buffers of IMG_W bits, addressed by hcount, written only on in_act. Each cycle they supply the KSIZE-1 pixels above (hcount,vcount).
- Window: KSIZE x KSIZE shift register, shifted left by one column on each in_act. The newest column is {line buffers, sobel_value}.
- Centre of the window is (hcount-R, vcount-R).
- Row validity counter lines_seen:
  - Cleared by rst and on in_act with hcount==0 && vcount==0.
  - Incremented at each in_act with hcount==IMG_W-1; saturates at KSIZE-1.
  - A window row j lines above the newest row is real iff lines_seen>=j; otherwise it is padding. Stale buffer contents after reset are always masked.
- Column padding: a window column k positions left of the newest is padding iff hcount<k.
- Padding value: 1 for the erode operand, 0 for the dilate operand, so borders are neither eroded nor dilated by out-of-image pixels.
- Operations:
  - ero = AND of the padded window; dil = OR of the padded window; ctr = centre tap.
  - mode 00 gives ero, 01 gives dil, 10 gives ctr, 11 gives dil XOR ero.
- Latency: input sampled at edge N enters the window. The result is registered at edge N+1 and is visible after it, i.e. exactly 2 clocks after the input is presented.
- Output registers:
  - out_valid = in_act && hcount>=R && vcount>=R.
  - out_hcount = hcount-R, out_vcount = vcount-R.
  - The last R columns and rows of the frame are not emitted.
  - When out_valid=0, morph_value=0 and rgb_out=0.
- mode is sampled with the pixel. A change mid-frame takes effect on the next output with no glitch and no pipeline flush.
- Reset (asynchronous): window, pipeline and all outputs go to 0 immediately and lines_seen=0. Line buffer RAM is not cleared. Processing resumes on the first in_act after release.

Decomposition:
- morph_pkg holds:
  - mode encodings MODE_ERODE/MODE_DILATE/MODE_BYPASS/MODE_GRAD
  - COLOR_ON/COLOR_OFF defaults
  - the pad-value constants
- Sub-module morph_linebuf: a single-port read-before-write 1-bit x IMG_W delay line, instantiated KSIZE-1 times as a cascade.

Test Plan:
- All-ones frame, mode 00, KSIZE 3 -> every out_valid pixel has morph_value=1 and rgb_out=12'hFFF, including row 0 and column 0.
- Single 1 at (10,10), rest 0:
  - mode 01 -> ones exactly at out coords x,y in 9..11.
  - mode 00 -> all 0.
  - mode 11 -> same 3x3 block.
- sobel_value=hcount[0] every line -> mode 00 all 0, mode 01 all 1, mode 11 all 1.
- Latency: inputs (h,v)=(20,5) and (21,5) on consecutive clocks -> 2 clocks later outputs (19,4) then (20,4), out_valid=1. With hcount=IMG_W, out_valid=0 two clocks later.
- Stale-buffer masking:
  - Zero frame up to row 5; assert rst mid-line.
  - Continue all-ones from row 5 -> outputs immediately 0 during rst.
  - After release, all emitted pixels =1 in mode 00.
- KSIZE=5 build, single 1 at (30,30), mode 01 -> 5x5 block at 28..32. First emitted coordinate is (0,0) when input is (2,2).
